// File: rtl/mext_pkg.sv
`default_nettype none
// ---- mext_pkg : encodings and result helpers for the M-extension issue controller (rev 1.0) ----
package mext_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] MC_MULS = 2'b00;
  localparam logic [1:0] MC_MULU = 2'b01;
  localparam logic [1:0] MC_DIVS = 2'b10;
  localparam logic [1:0] MC_DIVU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic logic [1:0] mc_op_of(input logic [2:0] funct3);
    logic [1:0] op;
    case (funct3)
      F3_MULH:                     op = MC_MULS;
      F3_MUL, F3_MULHSU, F3_MULHU: op = MC_MULU;
      F3_DIV, F3_REM:              op = MC_DIVS;
      default:                     op = MC_DIVU;
    endcase
    return op;
  endfunction

  function automatic logic [XLEN-1:0] select_result(
    input logic [2:0]      funct3,
    input logic [XLEN-1:0] rs1,
    input logic [XLEN-1:0] rs2,
    input logic [XLEN-1:0] result1,
    input logic [XLEN-1:0] result2
  );
    logic [XLEN-1:0] res;
    case (funct3)
      F3_MUL, F3_DIV, F3_DIVU: res = result1;
      // Unsigned product saw a negative rs1 as rs1 + 2^32; take rs2 back out of the high word.
      F3_MULHSU:               res = result2 - (rs1[XLEN-1] ? rs2 : '0);
      default:                 res = result2;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mext_special_case.sv
`default_nettype none
// ---- mext_special_case : detects RISC-V divide-by-zero / signed-overflow and their fixed results (rev 1.0) ----
module mext_special_case
  import mext_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic [WIDTH-1:0] rs2_i,
  output logic             is_special_o,
  output logic [WIDTH-1:0] special_data_o
);

  logic is_rem_w;
  logic div_zero_w;
  logic div_ovf_w;

  assign is_rem_w   = funct3_i[1];
  assign div_zero_w = funct3_i[2] && (rs2_i == '0);
  assign div_ovf_w  = ((funct3_i == F3_DIV) || (funct3_i == F3_REM)) &&
                      (rs1_i == {1'b1, {(WIDTH-1){1'b0}}}) && (rs2_i == '1);

  always_comb begin
    special_data_o = '0;
    if (div_zero_w) begin
      special_data_o = is_rem_w ? rs1_i : '1;
    end else if (div_ovf_w) begin
      special_data_o = is_rem_w ? '0 : rs1_i;
    end
  end

  assign is_special_o = div_zero_w | div_ovf_w;

endmodule
`default_nettype wire

// File: rtl/mext_issue_ctrl.sv
`default_nettype none
// ---- mext_issue_ctrl : RV32M request front-end driving a multi-cycle mul/div unit, with bypass and reuse (rev 1.0) ----
module mext_issue_ctrl
  import mext_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int ENABLE_REUSE = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_rs1,
  input  logic [WIDTH-1:0] req_rs2,
  input  logic [4:0]       req_rd,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic [4:0]       resp_rd,
  output logic             mc_start,
  output logic [1:0]       mc_op,
  output logic [WIDTH-1:0] mc_op1,
  output logic [WIDTH-1:0] mc_op2,
  input  logic             mc_busy,
  input  logic [WIDTH-1:0] mc_result1,
  input  logic [WIDTH-1:0] mc_result2
);

  state_e           state_q, state_d;
  logic             kill_q, kill_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [WIDTH-1:0] rs1_q, rs1_d;
  logic [WIDTH-1:0] rs2_q, rs2_d;
  logic [4:0]       rd_q, rd_d;
  logic             resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic [4:0]       resp_rd_q, resp_rd_d;
  logic             mc_start_q, mc_start_d;
  logic [1:0]       mc_op_q, mc_op_d;
  logic [WIDTH-1:0] mc_op1_q, mc_op1_d;
  logic [WIDTH-1:0] mc_op2_q, mc_op2_d;
  logic             cache_valid_q, cache_valid_d;
  logic [1:0]       cache_op_q, cache_op_d;
  logic [WIDTH-1:0] cache_rs1_q, cache_rs1_d;
  logic [WIDTH-1:0] cache_rs2_q, cache_rs2_d;
  logic [WIDTH-1:0] cache_r1_q, cache_r1_d;
  logic [WIDTH-1:0] cache_r2_q, cache_r2_d;

  logic             special_hit;
  logic [WIDTH-1:0] special_data;
  logic             reuse_hit;
  logic             accept;

  mext_special_case #(
    .WIDTH (WIDTH)
  ) u_special (
    .funct3_i       (req_funct3),
    .rs1_i          (req_rs1),
    .rs2_i          (req_rs2),
    .is_special_o   (special_hit),
    .special_data_o (special_data)
  );

  assign req_ready = ~RESET & (state_q == ST_IDLE) & ~flush;
  assign accept    = req_valid & req_ready;
  assign reuse_hit = (ENABLE_REUSE != 0) && cache_valid_q &&
                     (mc_op_of(req_funct3) == cache_op_q) &&
                     (req_rs1 == cache_rs1_q) && (req_rs2 == cache_rs2_q);

  always_comb begin
    state_d       = state_q;
    kill_d        = kill_q;
    funct3_d      = funct3_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    rd_d          = rd_q;
    resp_valid_d  = resp_valid_q;
    resp_data_d   = resp_data_q;
    resp_rd_d     = resp_rd_q;
    mc_start_d    = 1'b0;
    mc_op_d       = mc_op_q;
    mc_op1_d      = mc_op1_q;
    mc_op2_d      = mc_op2_q;
    cache_valid_d = cache_valid_q;
    cache_op_d    = cache_op_q;
    cache_rs1_d   = cache_rs1_q;
    cache_rs2_d   = cache_rs2_q;
    cache_r1_d    = cache_r1_q;
    cache_r2_d    = cache_r2_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          funct3_d = req_funct3;
          rs1_d    = req_rs1;
          rs2_d    = req_rs2;
          rd_d     = req_rd;
          if (special_hit) begin
            resp_valid_d = 1'b1;
            resp_data_d  = special_data;
            resp_rd_d    = req_rd;
            state_d      = ST_RESP;
          end else if (reuse_hit) begin
            resp_valid_d = 1'b1;
            resp_data_d  = select_result(req_funct3, req_rs1, req_rs2, cache_r1_q, cache_r2_q);
            resp_rd_d    = req_rd;
            state_d      = ST_RESP;
          end else begin
            mc_start_d = 1'b1;
            mc_op_d    = mc_op_of(req_funct3);
            mc_op1_d   = req_rs1;
            mc_op2_d   = req_rs2;
            state_d    = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        if (flush) kill_d = 1'b1;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (flush) kill_d = 1'b1;
        if (!mc_busy) begin
          // The unit cannot be aborted, so even a killed result is worth caching.
          cache_valid_d = 1'b1;
          cache_op_d    = mc_op_q;
          cache_rs1_d   = rs1_q;
          cache_rs2_d   = rs2_q;
          cache_r1_d    = mc_result1;
          cache_r2_d    = mc_result2;
          if (kill_q || flush) begin
            kill_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            resp_valid_d = 1'b1;
            resp_data_d  = select_result(funct3_q, rs1_q, rs2_q, mc_result1, mc_result2);
            resp_rd_d    = rd_q;
            state_d      = ST_RESP;
          end
        end
      end

      default: begin
        if (flush || resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      kill_q        <= 1'b0;
      funct3_q      <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      resp_rd_q     <= '0;
      mc_start_q    <= 1'b0;
      mc_op_q       <= '0;
      mc_op1_q      <= '0;
      mc_op2_q      <= '0;
      cache_valid_q <= 1'b0;
      cache_op_q    <= '0;
      cache_rs1_q   <= '0;
      cache_rs2_q   <= '0;
      cache_r1_q    <= '0;
      cache_r2_q    <= '0;
    end else begin
      state_q       <= state_d;
      kill_q        <= kill_d;
      funct3_q      <= funct3_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      rd_q          <= rd_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      resp_rd_q     <= resp_rd_d;
      mc_start_q    <= mc_start_d;
      mc_op_q       <= mc_op_d;
      mc_op1_q      <= mc_op1_d;
      mc_op2_q      <= mc_op2_d;
      cache_valid_q <= cache_valid_d;
      cache_op_q    <= cache_op_d;
      cache_rs1_q   <= cache_rs1_d;
      cache_rs2_q   <= cache_rs2_d;
      cache_r1_q    <= cache_r1_d;
      cache_r2_q    <= cache_r2_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_rd    = resp_rd_q;
  assign mc_start   = mc_start_q;
  assign mc_op      = mc_op_q;
  assign mc_op1     = mc_op1_q;
  assign mc_op2     = mc_op2_q;

endmodule
`default_nettype wire

// File: tb/tb_mext_issue_ctrl.sv
`default_nettype none
// ---- tb_mext_issue_ctrl : randomized scoreboard bench with an arithmetic RV32M model and an MCycle responder (rev 1.0) ----
module tb_mext_issue_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        req_valid, req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_rs1, req_rs2;
  logic [4:0]  req_rd;
  logic        flush;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        mc_start;
  logic [1:0]  mc_op;
  logic [31:0] mc_op1, mc_op2;
  logic        mc_busy;
  logic [31:0] mc_result1, mc_result2;

  always #5 CLK = ~CLK;

  mext_issue_ctrl #(.WIDTH(32), .ENABLE_REUSE(1)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_rd(resp_rd),
    .mc_start(mc_start), .mc_op(mc_op), .mc_op1(mc_op1), .mc_op2(mc_op2),
    .mc_busy(mc_busy), .mc_result1(mc_result1), .mc_result2(mc_result2)
  );

  typedef struct packed { logic [31:0] data; logic [4:0] rd; } resp_t;
  typedef struct packed { logic [1:0] op; logic [31:0] a; logic [31:0] b; } iss_t;

  resp_t resp_q[$];
  iss_t  iss_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  // Reference: RV32M results straight from the ISA definition.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [63:0] p;
    logic [31:0] r;
    logic ovf;
    sa = a; sb = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r = '0;
    case (f3)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; r = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'd4: if (b == 0) r = 32'hFFFF_FFFF; else if (ovf) r = 32'h8000_0000; else r = sa / sb;
      3'd5: if (b == 0) r = 32'hFFFF_FFFF; else r = a / b;
      3'd6: if (b == 0) r = a; else if (ovf) r = 32'h0; else r = sa % sb;
      default: if (b == 0) r = a; else r = a % b;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] exp_op(input logic [2:0] f3);
    case (f3)
      3'd1:       return 2'b00;
      3'd4, 3'd6: return 2'b10;
      3'd5, 3'd7: return 2'b11;
      default:    return 2'b01;
    endcase
  endfunction

  // Model of the reuse cache: remembers the last operation sent to the unit.
  bit          m_cv = 0;
  logic [1:0]  m_op;
  logic [31:0] m_a, m_b;

  // MCycle responder: Busy rises with Start, results appear when Busy falls.
  int          cnt = 0;
  int          lat_force = 0;
  int          pend_lat = 1;
  logic [31:0] pend1, pend2;

  assign mc_busy = mc_start | (cnt != 0);

  always @(negedge CLK) begin
    if (!RESET && mc_start) begin
      iss_t e;
      logic signed [31:0] sa, sb;
      logic [63:0] p;
      n_cmp++;
      if (iss_q.size() == 0) begin
        n_err++;
        $display("FAIL mc_start_unexpected: got op=%b op1=%h op2=%h, required no start", mc_op, mc_op1, mc_op2);
      end else begin
        e = iss_q.pop_front();
        if (mc_op !== e.op || mc_op1 !== e.a || mc_op2 !== e.b) begin
          n_err++;
          $display("FAIL mc_issue: got op=%b op1=%h op2=%h, required op=%b op1=%h op2=%h",
                   mc_op, mc_op1, mc_op2, e.op, e.a, e.b);
        end
      end
      sa = mc_op1; sb = mc_op2;
      case (mc_op)
        2'b00: begin p = {{32{mc_op1[31]}}, mc_op1} * {{32{mc_op2[31]}}, mc_op2}; pend1 = p[31:0]; pend2 = p[63:32]; end
        2'b01: begin p = {32'b0, mc_op1} * {32'b0, mc_op2}; pend1 = p[31:0]; pend2 = p[63:32]; end
        2'b10: begin
          if (mc_op2 == 0) begin pend1 = '1; pend2 = mc_op1; end
          else if (mc_op1 == 32'h8000_0000 && mc_op2 == '1) begin pend1 = mc_op1; pend2 = 0; end
          else begin pend1 = sa / sb; pend2 = sa % sb; end
        end
        default: begin
          if (mc_op2 == 0) begin pend1 = '1; pend2 = mc_op1; end
          else begin pend1 = mc_op1 / mc_op2; pend2 = mc_op1 % mc_op2; end
        end
      endcase
      pend_lat = (lat_force != 0) ? lat_force : int'($urandom_range(1, 6));
    end
  end

  always @(posedge CLK) begin
    if (RESET) begin
      cnt <= 0; mc_result1 <= '0; mc_result2 <= '0;
    end else if (mc_start) begin
      cnt <= pend_lat; mc_result1 <= 32'hDEAD_BEEF; mc_result2 <= 32'hBADC_0FFE;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin mc_result1 <= pend1; mc_result2 <= pend2; end
    end
  end

  // Response monitor: pops the scoreboard on each handshake, checks hold-stability while stalled.
  logic [31:0] prev_d;
  logic [4:0]  prev_rd;
  bit          prev_hold = 0;

  always @(negedge CLK) begin
    if (RESET) begin
      prev_hold = 0;
    end else if (resp_valid) begin
      resp_t e;
      if (prev_hold) begin
        n_cmp++;
        if (resp_data !== prev_d || resp_rd !== prev_rd) begin
          n_err++;
          $display("FAIL resp_stable: got data=%h rd=%0d, required data=%h rd=%0d", resp_data, resp_rd, prev_d, prev_rd);
        end
      end
      if (resp_ready) begin
        n_cmp++;
        if (resp_q.size() == 0) begin
          n_err++;
          $display("FAIL resp_unexpected: got data=%h rd=%0d, required no response", resp_data, resp_rd);
        end else begin
          e = resp_q.pop_front();
          if (resp_data !== e.data || resp_rd !== e.rd) begin
            n_err++;
            $display("FAIL resp_data: got data=%h rd=%0d, required data=%h rd=%0d", resp_data, resp_rd, e.data, e.rd);
          end
        end
        prev_hold = 0;
      end else begin
        prev_hold = 1; prev_d = resp_data; prev_rd = resp_rd;
      end
    end else begin
      if (prev_hold) begin
        n_cmp++; n_err++;
        $display("FAIL resp_dropped: resp_valid=0 before handshake, required 1");
      end
      prev_hold = 0;
    end
  end

  // Consumer back-pressure.
  bit rr_rand = 0;
  bit rr_low  = 0;
  initial begin
    resp_ready = 1'b0;
    forever begin
      @(posedge CLK); #1;
      resp_ready = rr_low ? 1'b0 : (rr_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  task automatic present(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output bit acc);
    int g;
    acc = 0; g = 0;
    req_valid = 1'b1; req_funct3 = f3; req_rs1 = a; req_rs2 = b; req_rd = rd;
    while (!acc && g < 200) begin
      @(negedge CLK); acc = req_ready;
      @(posedge CLK); #1; g++;
    end
    req_valid = 1'b0;
    if (!acc) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: req_ready=0 for %0d cycles, required 1", g);
    end
  endtask

  task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input bit fl);
    bit spec, hit, iss, acc;
    int g;
    resp_t r;
    iss_t  s;
    spec = f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    hit  = !spec && m_cv && (exp_op(f3) == m_op) && (a == m_a) && (b == m_b);
    iss  = !spec && !hit;
    fl   = fl && iss;
    if (iss) begin
      s.op = exp_op(f3); s.a = a; s.b = b; iss_q.push_back(s);
      m_cv = 1; m_op = exp_op(f3); m_a = a; m_b = b;
    end
    if (!fl) begin
      r.data = ref_result(f3, a, b); r.rd = rd; resp_q.push_back(r);
    end
    present(f3, a, b, rd, acc);
    if (!acc) return;
    if (!iss) begin
      @(negedge CLK);
      n_cmp++;
      if (resp_valid !== 1'b1) begin
        n_err++;
        $display("FAIL bypass_latency: resp_valid=%b one cycle after accept, required 1", resp_valid);
      end
      @(posedge CLK); #1;
    end
    if (fl) begin
      repeat ($urandom_range(0, 1)) begin @(posedge CLK); #1; end
      flush = 1'b1;
      @(posedge CLK); #1;
      flush = 1'b0;
      g = 0;
      do begin
        @(negedge CLK);
        if (mc_busy) begin
          n_cmp++;
          if (req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL flush_ready: req_ready=%b while killed op busy, required 0", req_ready);
          end
        end
        g++;
      end while (!req_ready && g < 200);
      @(posedge CLK); #1;
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (resp_q.size() != 0 && g < 400) begin @(posedge CLK); #1; g++; end
    n_cmp++;
    if (resp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", resp_q.size());
      resp_q.delete();
    end
    @(posedge CLK); #1;
  endtask

  task automatic check_zero(input string tag);
    n_cmp++;
    if ({req_ready, resp_valid, resp_data, resp_rd, mc_start, mc_op, mc_op1, mc_op2} !== '0) begin
      n_err++;
      $display("FAIL %s: got ready=%b rv=%b data=%h rd=%0d start=%b op=%b op1=%h op2=%h, required all 0",
               tag, req_ready, resp_valid, resp_data, resp_rd, mc_start, mc_op, mc_op1, mc_op2);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    bit          acc;
    int          g;

    RESET = 1'b1; req_valid = 1'b0; req_funct3 = '0; req_rs1 = '0; req_rs2 = '0; req_rd = '0; flush = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_zero("reset_state");
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK); #1;

    send(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 0);
    send(3'd1, 32'd7, 32'hFFFF_FFFD, 5'd2, 0);
    send(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 0);
    send(3'd3, 32'hFFFF_FFFF, 32'd2, 5'd4, 0);
    send(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 0);
    send(3'd5, 32'd5, 32'd0, 5'd6, 0);
    send(3'd7, 32'd5, 32'd0, 5'd7, 0);
    send(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd8, 0);
    send(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd9, 0);
    send(3'd0, 32'h1234, 32'h5678, 5'd10, 1);
    send(3'd0, 32'd3, 32'd4, 5'd17, 0);
    drain();

    // A request under flush in IDLE must be refused.
    req_valid = 1'b1; req_funct3 = 3'd5; req_rs1 = 32'd99; req_rs2 = 32'd7; req_rd = 5'd20; flush = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL idle_flush_ready: req_ready=%b under flush, required 0", req_ready);
    end
    @(posedge CLK); #1;
    req_valid = 1'b0; flush = 1'b0;
    repeat (3) @(posedge CLK); #1;

    // Consumer stalls for several cycles.
    rr_low = 1;
    send(3'd3, 32'hCAFE_0001, 32'h0001_0003, 5'd11, 0);
    g = 0;
    while (!resp_valid && g < 100) begin @(negedge CLK); g++; end
    repeat (3) @(posedge CLK); #1;
    rr_low = 0;
    drain();

    rr_rand = 1;
    a = 32'd1; b = 32'd1;
    for (int i = 0; i < 300; i++) begin
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) != 0) begin
        for (int k = 0; k < 2; k++) begin
          logic [31:0] v;
          case ($urandom_range(0, 5))
            0: v = 32'd0;
            1: v = 32'd1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = 32'($urandom_range(0, 15));
            default: v = $urandom;
          endcase
          if (k == 0) a = v; else b = v;
        end
      end
      send(f3, a, b, 5'($urandom_range(0, 31)), $urandom_range(0, 9) == 0);
    end
    drain();
    rr_rand = 0;

    // Reset while the unit is busy.
    lat_force = 20;
    begin
      iss_t s;
      s.op = 2'b01; s.a = 32'd9; s.b = 32'd9; iss_q.push_back(s);
    end
    present(3'd0, 32'd9, 32'd9, 5'd12, acc);
    repeat (3) begin @(posedge CLK); #1; end
    RESET = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    check_zero("reset_mid_wait");
    @(posedge CLK); #1;
    RESET = 1'b0; lat_force = 0; m_cv = 0;
    @(posedge CLK); #1;
    send(3'd0, 32'd3, 32'd4, 5'd21, 0);
    send(3'd1, 32'd3, 32'd4, 5'd22, 0);
    drain();

    n_cmp++;
    if (iss_q.size() != 0) begin
      n_err++;
      $display("FAIL issue_missing: %0d expected mc_start pulses not seen, required 0", iss_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
